mc_controller: RTL and testbench

//  Multicycle RV32IM main control FSM with memory handshakes, a MEM stage, PC-source selection, illegal-opcode trap
//  and EX watchdog. Drives the datapath; ex_controller stays combinational beside it for aluctl/mulctl/ifuresctl/mulstart.
//  One instruction in flight; retires are counted for perf/debug.

---
 rtl/mc_controller_if.sv | 39 +++
 rtl/mc_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle main control FSM and the datapath.
// master = controller side, slave = datapath side.
interface mc_controller_if #(
   parameter int unsigned pcmux_N = 4,
   parameter int unsigned CNT_W   = 32
);
   localparam int unsigned PCMUX_W = $clog2(pcmux_N);

   logic [6:0]         opcode;
   logic               imem_rdy;
   logic               dmem_rdy;
   logic               exdone;
   logic               brtaken;
   logic [PCMUX_W-1:0] pcmuxctl;
   logic               pcnextctl;
   logic               instrre;
   logic               regre;
   logic               regwe;
   logic               bmuxctl;
   logic               exstart;
   logic               memre;
   logic               memwe;
   logic [1:0]         wbsel;
   logic               trap;
   logic [1:0]         trapcause;
   logic [CNT_W-1:0]   instret;

   modport master (
      input  opcode, imem_rdy, dmem_rdy, exdone, brtaken,
      output pcmuxctl, pcnextctl, instrre, regre, regwe, bmuxctl, exstart,
             memre, memwe, wbsel, trap, trapcause, instret
   );

   modport slave (
      output opcode, imem_rdy, dmem_rdy, exdone, brtaken,
      input  pcmuxctl, pcnextctl, instrre, regre, regwe, bmuxctl, exstart,
             memre, memwe, wbsel, trap, trapcause, instret
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle RV32IM main control FSM: IF/ID/EX/MEM/WB sequencing with memory handshakes,
// PC-source selection, illegal-opcode trap, EX watchdog and retired-instruction counter.
module mc_controller #(
   parameter int unsigned pcmux_N    = 4,
   parameter int unsigned EX_TIMEOUT = 64,
   parameter int unsigned CNT_W      = 32
) (
   input  logic            clk,
   input  logic            rst,
   mc_controller_if.master bus
);
   localparam int unsigned PCMUX_W = $clog2(pcmux_N);
   localparam int unsigned WD_W    = $clog2(EX_TIMEOUT);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [PCMUX_W-1:0] PCSEL_SEQ  = PCMUX_W'(0);
   localparam logic [PCMUX_W-1:0] PCSEL_REL  = PCMUX_W'(1);
   localparam logic [PCMUX_W-1:0] PCSEL_JALR = PCMUX_W'(2);

   localparam logic [1:0] WB_EX   = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_EXTO    = 2'd2;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
   typedef enum logic [2:0] {C_ALU, C_BRANCH, C_LOAD, C_STORE, C_JAL, C_JALR} iclass_t;

   state_t             state, state_nx;
   iclass_t            iclass_q, iclass_nx;
   iclass_t            dec_class;
   logic               dec_legal, dec_bmux;
   logic [WD_W-1:0]    wd_q, wd_nx;
   logic [CNT_W-1:0]   instret_q, instret_nx;
   logic [PCMUX_W-1:0] pcmuxctl_q, pcmuxctl_nx;
   logic [1:0]         wbsel_q, wbsel_nx;
   logic [1:0]         trapcause_q, trapcause_nx;
   logic               pcnextctl_q, pcnextctl_nx;
   logic               instrre_q, instrre_nx;
   logic               regre_q, regre_nx;
   logic               regwe_q, regwe_nx;
   logic               bmuxctl_q, bmuxctl_nx;
   logic               exstart_q, exstart_nx;
   logic               memre_q, memre_nx;
   logic               memwe_q, memwe_nx;
   logic               trap_q, trap_nx;

   // Opcode decode: instruction class, ALU-B source and legality
   always_comb begin
      dec_legal = 1'b1;
      dec_bmux  = 1'b0;
      dec_class = C_ALU;
      case (bus.opcode)
         OPC_OP:                        dec_bmux  = 1'b1;
         OPC_BRANCH: begin              dec_bmux  = 1'b1; dec_class = C_BRANCH; end
         OPC_OPIMM, OPC_LUI, OPC_AUIPC: dec_class = C_ALU;
         OPC_LOAD:                      dec_class = C_LOAD;
         OPC_STORE:                     dec_class = C_STORE;
         OPC_JAL:                       dec_class = C_JAL;
         OPC_JALR:                      dec_class = C_JALR;
         default:                       dec_legal = 1'b0;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_nx     = state;
      iclass_nx    = iclass_q;
      wd_nx        = '0;
      instret_nx   = instret_q;
      pcmuxctl_nx  = PCSEL_SEQ;
      wbsel_nx     = WB_EX;
      pcnextctl_nx = 1'b0;
      instrre_nx   = 1'b0;
      regre_nx     = 1'b0;
      regwe_nx     = 1'b0;
      exstart_nx   = 1'b0;
      memre_nx     = 1'b0;
      memwe_nx     = 1'b0;
      bmuxctl_nx   = bmuxctl_q;
      trap_nx      = trap_q;
      trapcause_nx = trapcause_q;

      case (state)
         S_IF: begin
            // Request goes up one cycle after entering IF, drops once the fetch completes
            if (instrre_q && bus.imem_rdy) begin
               state_nx = S_ID;
               regre_nx = 1'b1;
            end else begin
               instrre_nx = 1'b1;
            end
         end
         S_ID: begin
            if (!dec_legal) begin
               state_nx     = S_TRAP;
               trap_nx      = 1'b1;
               trapcause_nx = CAUSE_ILLEGAL;
               bmuxctl_nx   = 1'b0;
            end else begin
               state_nx   = S_EX;
               exstart_nx = 1'b1;
               bmuxctl_nx = dec_bmux;
               iclass_nx  = dec_class;
            end
         end
         S_EX: begin
            if (bus.exdone) begin
               case (iclass_q)
                  C_LOAD: begin
                     state_nx = S_MEM;
                     memre_nx = 1'b1;
                  end
                  C_STORE: begin
                     state_nx = S_MEM;
                     memwe_nx = 1'b1;
                  end
                  C_BRANCH: begin
                     state_nx     = S_IF;
                     pcnextctl_nx = 1'b1;
                     pcmuxctl_nx  = bus.brtaken ? PCSEL_REL : PCSEL_SEQ;
                     instret_nx   = instret_q + CNT_W'(1);
                  end
                  default: begin
                     state_nx     = S_WB;
                     regwe_nx     = 1'b1;
                     pcnextctl_nx = 1'b1;
                     wbsel_nx     = (iclass_q == C_JAL || iclass_q == C_JALR) ? WB_PC4 : WB_EX;
                     pcmuxctl_nx  = (iclass_q == C_JAL)  ? PCSEL_REL :
                                    (iclass_q == C_JALR) ? PCSEL_JALR : PCSEL_SEQ;
                  end
               endcase
            end else if (wd_q == WD_W'(EX_TIMEOUT - 1)) begin
               state_nx     = S_TRAP;
               trap_nx      = 1'b1;
               trapcause_nx = CAUSE_EXTO;
               bmuxctl_nx   = 1'b0;
            end else begin
               wd_nx = wd_q + WD_W'(1);
            end
         end
         S_MEM: begin
            if (bus.dmem_rdy) begin
               if (iclass_q == C_LOAD) begin
                  state_nx     = S_WB;
                  regwe_nx     = 1'b1;
                  pcnextctl_nx = 1'b1;
                  wbsel_nx     = WB_LOAD;
               end else begin
                  state_nx     = S_IF;
                  pcnextctl_nx = 1'b1;
                  instret_nx   = instret_q + CNT_W'(1);
               end
            end else begin
               memre_nx = memre_q;
               memwe_nx = memwe_q;
            end
         end
         S_WB: begin
            state_nx   = S_IF;
            instret_nx = instret_q + CNT_W'(1);
         end
         S_TRAP: ;
         default: state_nx = S_IF;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IF;
         iclass_q    <= C_ALU;
         wd_q        <= '0;
         instret_q   <= '0;
         pcmuxctl_q  <= '0;
         wbsel_q     <= '0;
         trapcause_q <= '0;
         pcnextctl_q <= 1'b0;
         instrre_q   <= 1'b0;
         regre_q     <= 1'b0;
         regwe_q     <= 1'b0;
         bmuxctl_q   <= 1'b0;
         exstart_q   <= 1'b0;
         memre_q     <= 1'b0;
         memwe_q     <= 1'b0;
         trap_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         iclass_q    <= iclass_nx;
         wd_q        <= wd_nx;
         instret_q   <= instret_nx;
         pcmuxctl_q  <= pcmuxctl_nx;
         wbsel_q     <= wbsel_nx;
         trapcause_q <= trapcause_nx;
         pcnextctl_q <= pcnextctl_nx;
         instrre_q   <= instrre_nx;
         regre_q     <= regre_nx;
         regwe_q     <= regwe_nx;
         bmuxctl_q   <= bmuxctl_nx;
         exstart_q   <= exstart_nx;
         memre_q     <= memre_nx;
         memwe_q     <= memwe_nx;
         trap_q      <= trap_nx;
      end
   end

   assign bus.pcmuxctl  = pcmuxctl_q;
   assign bus.pcnextctl = pcnextctl_q;
   assign bus.instrre   = instrre_q;
   assign bus.regre     = regre_q;
   assign bus.regwe     = regwe_q;
   assign bus.bmuxctl   = bmuxctl_q;
   assign bus.exstart   = exstart_q;
   assign bus.memre     = memre_q;
   assign bus.memwe     = memwe_q;
   assign bus.wbsel     = wbsel_q;
   assign bus.trap      = trap_q;
   assign bus.trapcause = trapcause_q;
   assign bus.instret   = instret_q;
endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: a responsive datapath/memory model drives the handshakes,
// and per-instruction observations are compared with expectations derived from the opcode class.
module tb_mc_controller;
   localparam int unsigned PCMUX_N = 4;
   localparam int unsigned EX_TO   = 4;
   localparam int unsigned CW      = 5;
   localparam int unsigned PCW     = $clog2(PCMUX_N);

   localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_JAL = 4, K_JALR = 5, K_ILL = 6;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   logic [CW-1:0] exp_ret;
   logic [6:0] legal_ops [9];
   logic [6:0] bad_ops   [4];

   mc_controller_if #(.pcmux_N(PCMUX_N), .CNT_W(CW)) bus ();

   mc_controller #(.pcmux_N(PCMUX_N), .EX_TIMEOUT(EX_TO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic int cls_of(input logic [6:0] op);
      case (op)
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
         7'b1100011: return K_BR;
         7'b0000011: return K_LD;
         7'b0100011: return K_ST;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         default:    return K_ILL;
      endcase
   endfunction

   // Every output except instrre, packed for all-zero checks
   function automatic logic [31:0] others();
      return 32'({bus.pcmuxctl, bus.pcnextctl, bus.regre, bus.regwe, bus.bmuxctl, bus.exstart,
                  bus.memre, bus.memwe, bus.wbsel, bus.trap, bus.trapcause, bus.instret});
   endfunction

   task automatic reset_dut(input int n);
      rst          = 1'b1;
      bus.opcode   = 7'd0;
      bus.imem_rdy = 1'b0;
      bus.dmem_rdy = 1'b0;
      bus.exdone   = 1'b0;
      bus.brtaken  = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      chk("rst_instrre", 32'(bus.instrre), 32'd0);
      chk("rst_memre", 32'(bus.memre), 32'd0);
      chk("rst_outs", others(), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rel_instrre", 32'(bus.instrre), 32'd1);
      chk("rel_outs", others(), 32'd0);
      exp_ret = '0;
   endtask

   // Runs one instruction starting on the first cycle its fetch request is high.
   // iw: extra imem wait cycles, ew: EX cycle index (0-based) of exdone or -1 for never,
   // dw: extra dmem wait cycles.
   task automatic run_instr(input logic [6:0] op, input int iw, input int ew, input logic bt,
                            input int dw);
      int k, base, cyc, ifn, exn, memn;
      int n_rre, n_we, n_pcn, n_exs, n_mre, n_mwe, n_trap, n_trap_en;
      logic seen_ex, done_ex, both, fin, bm_obs, is_to, exp_we;
      logic [1:0] wb_obs, tc_obs, exp_wb;
      logic [PCW-1:0] pm_obs, exp_pm;
      k     = cls_of(op);
      is_to = (k != K_ILL) && (ew < 0 || ew >= int'(EX_TO));
      cyc = 0; ifn = 0; exn = 0; memn = 0;
      n_rre = 0; n_we = 0; n_pcn = 0; n_exs = 0; n_mre = 0; n_mwe = 0; n_trap = 0; n_trap_en = 0;
      seen_ex = 0; done_ex = 0; both = 0; fin = 0; bm_obs = 0;
      wb_obs = '0; tc_obs = '0; pm_obs = '0;
      while (!fin) begin
         if (bus.instrre) ifn++;
         if (bus.regre) n_rre++;
         if (bus.exstart) begin
            n_exs++;
            bm_obs  = bus.bmuxctl;
            seen_ex = 1'b1;
         end
         if (seen_ex && !done_ex && !bus.trap) exn++;
         if (bus.regwe) begin n_we++; wb_obs = bus.wbsel; end
         if (bus.pcnextctl) begin n_pcn++; pm_obs = bus.pcmuxctl; end
         if (bus.memre) n_mre++;
         if (bus.memwe) n_mwe++;
         if (bus.memre && bus.memwe) both = 1'b1;
         if (bus.memre || bus.memwe) memn++;
         if (bus.trap) begin
            n_trap++;
            tc_obs = bus.trapcause;
            if (bus.instrre | bus.regre | bus.regwe | bus.pcnextctl | bus.memre | bus.memwe |
                bus.exstart) n_trap_en++;
         end
         bus.imem_rdy = bus.instrre && (ifn > iw);
         bus.opcode   = (n_rre == 0 && !bus.imem_rdy) ? 7'($urandom) : op;
         bus.exdone   = seen_ex && !done_ex && !bus.trap && (ew >= 0) && (exn == ew + 1);
         bus.brtaken  = bus.exdone ? bt : 1'($urandom);
         if (bus.exdone) done_ex = 1'b1;
         bus.dmem_rdy = (bus.memre || bus.memwe) && (memn > dw);
         @(posedge clk); #1;
         cyc++;
         if (bus.instrre && n_rre > 0) fin = 1'b1;
         if (n_trap >= 6) fin = 1'b1;
         if (cyc > 300) begin
            chk("instr_budget", 32'(cyc), 32'd300);
            fin = 1'b1;
         end
      end
      bus.exdone   = 1'b0;
      bus.dmem_rdy = 1'b0;
      bus.imem_rdy = 1'b0;
      chk("regre_cycles", 32'(n_rre), 32'd1);
      if (k == K_ILL || is_to) begin
         chk("trap_cause", 32'(tc_obs), (k == K_ILL) ? 32'd1 : 32'd2);
         chk("trap_exstart", 32'(n_exs), (k == K_ILL) ? 32'd0 : 32'd1);
         chk("trap_enables", 32'(n_trap_en), 32'd0);
         chk("trap_pcnext", 32'(n_pcn), 32'd0);
         chk("trap_regwe", 32'(n_we), 32'd0);
         chk("trap_instret", 32'(bus.instret), 32'(exp_ret));
         if (is_to) chk("to_ex_cycles", 32'(exn), 32'(EX_TO));
      end else begin
         base   = (k == K_BR) ? 4 : (k == K_LD) ? 6 : 5;
         exp_we = !(k == K_BR || k == K_ST);
         exp_wb = (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LD) ? 2'd1 : 2'd0;
         exp_pm = (k == K_BR) ? PCW'(bt) : (k == K_JAL) ? PCW'(1) : (k == K_JALR) ? PCW'(2) : PCW'(0);
         exp_ret = exp_ret + CW'(1);
         chk("no_trap", 32'(n_trap), 32'd0);
         chk("exstart_pulses", 32'(n_exs), 32'd1);
         chk("bmuxctl", 32'(bm_obs), 32'(op == 7'b0110011 || op == 7'b1100011));
         chk("regwe_cycles", 32'(n_we), 32'(exp_we));
         if (exp_we) chk("wbsel", 32'(wb_obs), 32'(exp_wb));
         chk("pcnext_cycles", 32'(n_pcn), 32'd1);
         chk("pcmuxctl", 32'(pm_obs), 32'(exp_pm));
         chk("memre_cycles", 32'(n_mre), (k == K_LD) ? 32'(dw + 1) : 32'd0);
         chk("memwe_cycles", 32'(n_mwe), (k == K_ST) ? 32'(dw + 1) : 32'd0);
         chk("mem_exclusive", 32'(both), 32'd0);
         chk("instr_cycles", 32'(cyc),
             32'(base + iw + ew + ((k == K_LD || k == K_ST) ? dw : 0)));
         chk((exp_ret == '0) ? "instret_wrap" : "instret", 32'(bus.instret), 32'(exp_ret));
      end
   endtask

   task automatic reset_mid_mem();
      int   cyc;
      logic seen_mem;
      cyc = 0;
      seen_mem = 1'b0;
      bus.opcode = 7'b0000011;
      while (!seen_mem && cyc < 30) begin
         bus.imem_rdy = bus.instrre;
         bus.exdone   = bus.exstart;
         bus.dmem_rdy = 1'b0;
         @(posedge clk); #1;
         cyc++;
         if (bus.memre) seen_mem = 1'b1;
      end
      chk("mem_reached", 32'(seen_mem), 32'd1);
      reset_dut(1);
   endtask

   initial begin
      int op_i, ew;
      n_chk   = 0;
      n_pass  = 0;
      exp_ret = '0;
      legal_ops = '{7'b0110011, 7'b1100011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111};
      bad_ops   = '{7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};
      reset_dut(3);

      run_instr(7'b0110011, 3, 1, 1'b0, 0);  // ADD, slow fetch, exdone on 2nd EX cycle
      run_instr(7'b1100011, 0, 0, 1'b1, 0);  // BEQ taken
      run_instr(7'b1100011, 0, 0, 1'b0, 0);  // BEQ not taken
      run_instr(7'b0000011, 0, 0, 1'b0, 3);  // LW, dmem ready on 4th MEM cycle
      run_instr(7'b0100011, 1, 0, 1'b0, 0);  // SW
      run_instr(7'b1100111, 0, 0, 1'b0, 0);  // JALR
      run_instr(7'b1101111, 0, 2, 1'b0, 0);  // JAL
      run_instr(7'b0110111, 0, 0, 1'b0, 0);  // LUI
      run_instr(7'b1111111, 0, 0, 1'b0, 0);  // illegal opcode
      reset_dut(2);
      run_instr(7'b0110011, 0, -1, 1'b0, 0); // EX watchdog expiry
      reset_dut(1);
      run_instr(7'b0110011, 0, int'(EX_TO) - 1, 1'b0, 0); // exdone on the last allowed cycle
      reset_mid_mem();

      // Long legal run so the retire counter wraps
      repeat (40) begin
         op_i = $urandom_range(0, 8);
         run_instr(legal_ops[op_i], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 4));
      end

      // Mixed run with occasional traps
      repeat (80) begin
         op_i = $urandom_range(0, 8);
         ew   = ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 3);
         if ($urandom_range(0, 15) == 0)
            run_instr(bad_ops[$urandom_range(0, 3)], $urandom_range(0, 2), 0, 1'b0, 0);
         else
            run_instr(legal_ops[op_i], $urandom_range(0, 2), ew, 1'($urandom),
                      $urandom_range(0, 3));
         if (bus.trap) reset_dut($urandom_range(1, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
